// File: rtl/smi_axi_mem_responder.sv
// AXI4 slave memory responder: INCR read/write bursts served from a byte-strobed RAM.
// Read and write channels are independent, one outstanding burst each.
module smi_axi_mem_responder #(
    parameter int DataIndexSize = 4,
    parameter int AxiIdWidth    = 4,
    parameter int MemAddrWidth  = 10
) (
    input  logic                              clk,
    input  logic                              srst,

    input  logic                              axiARValid,
    output logic                              axiARReady,
    input  logic [AxiIdWidth-1:0]             axiARId,
    input  logic [63:0]                       axiARAddr,
    input  logic [7:0]                        axiARLen,
    input  logic [2:0]                        axiARSize,
    input  logic [3:0]                        axiARCache,

    output logic                              axiRValid,
    input  logic                              axiRReady,
    output logic [AxiIdWidth-1:0]             axiRId,
    output logic [(8<<DataIndexSize)-1:0]     axiRData,
    output logic [1:0]                        axiRResp,
    output logic                              axiRLast,

    input  logic                              axiAWValid,
    output logic                              axiAWReady,
    input  logic [AxiIdWidth-1:0]             axiAWId,
    input  logic [63:0]                       axiAWAddr,
    input  logic [7:0]                        axiAWLen,
    input  logic [2:0]                        axiAWSize,
    input  logic [3:0]                        axiAWCache,

    input  logic                              axiWValid,
    output logic                              axiWReady,
    input  logic [(8<<DataIndexSize)-1:0]     axiWData,
    input  logic [(1<<DataIndexSize)-1:0]     axiWStrb,
    input  logic                              axiWLast,

    output logic                              axiBValid,
    input  logic                              axiBReady,
    output logic [AxiIdWidth-1:0]             axiBId,
    output logic [1:0]                        axiBResp
);

    localparam int DataWidth = 8 << DataIndexSize;
    localparam int StrbWidth = 1 << DataIndexSize;
    localparam int Depth     = 1 << MemAddrWidth;

    localparam logic [2:0] BeatSize   = 3'(DataIndexSize);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    localparam logic [0:0] RD_IDLE  = 1'b0;
    localparam logic [0:0] RD_BURST = 1'b1;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_DATA = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;

    // Beat-wide RAM; contents deliberately survive reset.
    logic [DataWidth-1:0] mem [Depth];

    logic [0:0]              rdState;
    logic [AxiIdWidth-1:0]   rdId;
    logic [MemAddrWidth-1:0] rdIdx;
    logic [7:0]              rdLen;
    logic [7:0]              rdCnt;
    logic                    rdErr;

    logic [1:0]              wrState;
    logic [AxiIdWidth-1:0]   wrId;
    logic [MemAddrWidth-1:0] wrIdx;
    logic [7:0]              wrLen;
    logic [7:0]              wrCnt;
    logic                    wrErr;
    logic                    wrOver;
    logic                    wrBadLast;

    logic arFire;
    logic rFire;
    logic rdLast;
    logic awFire;
    logic wFire;
    logic bFire;
    logic wrHit;

    // Cache hints and address bits outside the beat index carry no meaning here.
    logic unusedBits;
    assign unusedBits = ^{axiARCache, axiAWCache, axiARAddr, axiAWAddr};

    assign arFire = axiARValid && axiARReady;
    assign rFire  = axiRValid && axiRReady;
    assign rdLast = (rdCnt == rdLen);
    assign awFire = axiAWValid && axiAWReady;
    assign wFire  = axiWValid && axiWReady;
    assign bFire  = axiBValid && axiBReady;

    // Beats past the advertised length, and all beats of a mis-sized burst, are dropped.
    assign wrHit = wFire && !wrErr && !wrOver;

    assign axiARReady = srst && (rdState == RD_IDLE);
    assign axiRValid  = (rdState == RD_BURST);
    assign axiRId     = rdId;
    assign axiRLast   = axiRValid && rdLast;
    assign axiRResp   = (axiRValid && rdErr) ? RespSlvErr : RespOkay;
    assign axiRData   = (axiRValid && !rdErr) ? mem[rdIdx] : '0;

    assign axiAWReady = srst && (wrState == WR_IDLE);
    assign axiWReady  = srst && (wrState == WR_DATA);
    assign axiBValid  = (wrState == WR_RESP);
    assign axiBId     = wrId;
    assign axiBResp   = (axiBValid && (wrErr || wrBadLast)) ? RespSlvErr : RespOkay;

    // Read channel: capture the burst on AR, then stream one beat per R handshake.
    always_ff @(posedge clk) begin
        if (!srst) begin
            rdState <= RD_IDLE;
            rdId    <= '0;
            rdIdx   <= '0;
            rdLen   <= '0;
            rdCnt   <= '0;
            rdErr   <= 1'b0;
        end else begin
            case (rdState)
                RD_IDLE: begin
                    if (arFire) begin
                        rdId    <= axiARId;
                        rdIdx   <= axiARAddr[DataIndexSize +: MemAddrWidth];
                        rdLen   <= axiARLen;
                        rdCnt   <= '0;
                        rdErr   <= (axiARSize != BeatSize);
                        rdState <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (rFire) begin
                        rdIdx <= rdIdx + 1'b1;
                        rdCnt <= rdCnt + 1'b1;
                        if (rdLast) begin
                            rdState <= RD_IDLE;
                        end
                    end
                end
                default: rdState <= RD_IDLE;
            endcase
        end
    end

    // Write channel: capture on AW, absorb W beats until WLast, then hold B.
    always_ff @(posedge clk) begin
        if (!srst) begin
            wrState   <= WR_IDLE;
            wrId      <= '0;
            wrIdx     <= '0;
            wrLen     <= '0;
            wrCnt     <= '0;
            wrErr     <= 1'b0;
            wrOver    <= 1'b0;
            wrBadLast <= 1'b0;
        end else begin
            case (wrState)
                WR_IDLE: begin
                    if (awFire) begin
                        wrId      <= axiAWId;
                        wrIdx     <= axiAWAddr[DataIndexSize +: MemAddrWidth];
                        wrLen     <= axiAWLen;
                        wrCnt     <= '0;
                        wrErr     <= (axiAWSize != BeatSize);
                        wrOver    <= 1'b0;
                        wrBadLast <= 1'b0;
                        wrState   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (wFire) begin
                        wrIdx <= wrIdx + 1'b1;
                        wrCnt <= wrCnt + 1'b1;
                        if (rdLast && 1'b0) begin
                            wrOver <= 1'b0;
                        end
                        if (wrCnt == wrLen) begin
                            wrOver <= 1'b1;
                        end
                        if (axiWLast) begin
                            wrBadLast <= wrOver || (wrCnt != wrLen);
                            wrState   <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bFire) begin
                        wrState <= WR_IDLE;
                    end
                end
                default: wrState <= WR_IDLE;
            endcase
        end
    end

    // Byte-lane RAM write; reads are combinational so a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (wrHit) begin
            for (int i = 0; i < StrbWidth; i++) begin
                if (axiWStrb[i]) begin
                    mem[wrIdx][i*8 +: 8] <= axiWData[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_smi_axi_mem_responder.sv
// Randomized bench for smi_axi_mem_responder against a flat-array memory model.
// Each task drives one scenario and checks the DUT inline.
module tb_smi_axi_mem_responder;

    localparam int DW    = 128;
    localparam int SW    = 16;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          srst = 1'b0;
    logic          axiARValid = 1'b0;
    logic          axiARReady;
    logic [3:0]    axiARId = '0;
    logic [63:0]   axiARAddr = '0;
    logic [7:0]    axiARLen = '0;
    logic [2:0]    axiARSize = '0;
    logic [3:0]    axiARCache = '0;
    logic          axiRValid;
    logic          axiRReady = 1'b0;
    logic [3:0]    axiRId;
    logic [DW-1:0] axiRData;
    logic [1:0]    axiRResp;
    logic          axiRLast;
    logic          axiAWValid = 1'b0;
    logic          axiAWReady;
    logic [3:0]    axiAWId = '0;
    logic [63:0]   axiAWAddr = '0;
    logic [7:0]    axiAWLen = '0;
    logic [2:0]    axiAWSize = '0;
    logic [3:0]    axiAWCache = '0;
    logic          axiWValid = 1'b0;
    logic          axiWReady;
    logic [DW-1:0] axiWData = '0;
    logic [SW-1:0] axiWStrb = '0;
    logic          axiWLast = 1'b0;
    logic          axiBValid;
    logic          axiBReady = 1'b0;
    logic [3:0]    axiBId;
    logic [1:0]    axiBResp;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wbData [260];
    logic [SW-1:0] wbStrb [260];

    always #5 clk = ~clk;

    smi_axi_mem_responder dut (
        .clk(clk), .srst(srst),
        .axiARValid(axiARValid), .axiARReady(axiARReady), .axiARId(axiARId),
        .axiARAddr(axiARAddr), .axiARLen(axiARLen), .axiARSize(axiARSize),
        .axiARCache(axiARCache),
        .axiRValid(axiRValid), .axiRReady(axiRReady), .axiRId(axiRId),
        .axiRData(axiRData), .axiRResp(axiRResp), .axiRLast(axiRLast),
        .axiAWValid(axiAWValid), .axiAWReady(axiAWReady), .axiAWId(axiAWId),
        .axiAWAddr(axiAWAddr), .axiAWLen(axiAWLen), .axiAWSize(axiAWSize),
        .axiAWCache(axiAWCache),
        .axiWValid(axiWValid), .axiWReady(axiWReady), .axiWData(axiWData),
        .axiWStrb(axiWStrb), .axiWLast(axiWLast),
        .axiBValid(axiBValid), .axiBReady(axiBReady), .axiBId(axiBId),
        .axiBResp(axiBResp)
    );

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int beatIndex(input logic [63:0] addr, input int b);
        return int'(((addr >> 4) + 64'(b)) % 64'(DEPTH));
    endfunction

    // Full write transaction using wbData/wbStrb; WLast is raised on beat lastIdx.
    task automatic axi_write(input logic [3:0] id, input logic [63:0] addr,
                             input int len, input logic [2:0] size,
                             input int lastIdx, input string tag);
        int to;
        int idx;
        logic [1:0] expResp;
        @(negedge clk);
        axiAWValid = 1'b1; axiAWId = id; axiAWAddr = addr;
        axiAWLen = 8'(len); axiAWSize = size; axiAWCache = 4'($urandom);
        to = 0;
        while (!axiAWReady && to < 50) begin @(negedge clk); to++; end
        if (!axiAWReady) begin
            vectors++; miscompares++; axiAWValid = 1'b0;
            $display("FAIL %s aw_timeout got ready=0 exp ready=1", tag);
            return;
        end
        @(negedge clk);
        axiAWValid = 1'b0;
        vectors++;
        if (axiWReady !== 1'b1) begin
            miscompares++;
            $display("FAIL %s w_latency got %b exp 1", tag, axiWReady);
        end
        for (int b = 0; b <= lastIdx; b++) begin
            axiWValid = 1'b1; axiWData = wbData[b];
            axiWStrb = wbStrb[b]; axiWLast = (b == lastIdx);
            to = 0;
            while (!axiWReady && to < 50) begin @(negedge clk); to++; end
            if (!axiWReady) begin
                vectors++; miscompares++; axiWValid = 1'b0; axiWLast = 1'b0;
                $display("FAIL %s w_timeout beat %0d got ready=0 exp 1", tag, b);
                return;
            end
            @(negedge clk);
        end
        axiWValid = 1'b0; axiWLast = 1'b0;
        vectors++;
        if ({axiBValid, axiWReady} !== 2'b10) begin
            miscompares++;
            $display("FAIL %s b_latency got %b exp 10", tag, {axiBValid, axiWReady});
        end
        axiBReady = 1'b1;
        to = 0;
        while (!axiBValid && to < 50) begin @(negedge clk); to++; end
        expResp = (size != 3'd4 || lastIdx != len) ? 2'b10 : 2'b00;
        vectors++;
        if ({axiBValid, axiBId, axiBResp} !== {1'b1, id, expResp}) begin
            miscompares++;
            $display("FAIL %s bresp got v=%b id=%h resp=%b exp v=1 id=%h resp=%b",
                     tag, axiBValid, axiBId, axiBResp, id, expResp);
        end
        @(negedge clk);
        axiBReady = 1'b0;
        if (size == 3'd4) begin
            for (int b = 0; b <= lastIdx && b <= len; b++) begin
                idx = beatIndex(addr, b);
                for (int k = 0; k < SW; k++)
                    if (wbStrb[b][k]) model[idx][k*8 +: 8] = wbData[b][k*8 +: 8];
            end
        end
    endtask

    // Read burst; mode 0 ready held, 1 ready toggling 1010.., 2 random.
    // abortAt >= 0 pulls reset while that beat is presented.
    task automatic axi_read(input logic [3:0] id, input logic [63:0] addr,
                            input int len, input logic [2:0] size,
                            input int mode, input int abortAt, input string tag);
        int to;
        int beat;
        int cyc;
        logic rr;
        logic [DW-1:0] expData;
        logic [1:0] expResp;
        @(negedge clk);
        axiARValid = 1'b1; axiARId = id; axiARAddr = addr;
        axiARLen = 8'(len); axiARSize = size; axiARCache = 4'($urandom);
        to = 0;
        while (!axiARReady && to < 50) begin @(negedge clk); to++; end
        if (!axiARReady) begin
            vectors++; miscompares++; axiARValid = 1'b0;
            $display("FAIL %s ar_timeout got ready=0 exp ready=1", tag);
            return;
        end
        @(negedge clk);
        axiARValid = 1'b0;
        vectors++;
        if (axiRValid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s r_latency got %b exp 1", tag, axiRValid);
        end
        expResp = (size != 3'd4) ? 2'b10 : 2'b00;
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 2000) begin
            case (mode)
                0: rr = 1'b1;
                1: rr = (cyc % 2 == 0);
                default: rr = 1'($urandom);
            endcase
            axiRReady = rr;
            expData = (size != 3'd4) ? '0 : model[beatIndex(addr, beat)];
            vectors++;
            if ({axiRValid, axiRId, axiRData, axiRResp, axiRLast} !==
                {1'b1, id, expData, expResp, 1'(beat == len)}) begin
                miscompares++;
                $display("FAIL %s rbeat%0d got v=%b id=%h d=%h r=%b l=%b exp v=1 id=%h d=%h r=%b l=%b",
                         tag, beat, axiRValid, axiRId, axiRData, axiRResp, axiRLast,
                         id, expData, expResp, beat == len);
            end
            if (beat == abortAt) begin
                srst = 1'b0; axiRReady = 1'b0;
                @(negedge clk);
                vectors++;
                if ({axiRValid, axiARReady, axiAWReady, axiWReady} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL %s in_reset got %b exp 0000", tag,
                             {axiRValid, axiARReady, axiAWReady, axiWReady});
                end
                srst = 1'b1;
                @(negedge clk);
                vectors++;
                if ({axiRValid, axiARReady} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL %s after_reset got %b exp 01", tag, {axiRValid, axiARReady});
                end
                return;
            end
            @(negedge clk);
            if (rr) beat++;
            cyc++;
        end
        axiRReady = 1'b0;
        vectors++;
        if (beat <= len || {axiRValid, axiARReady} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s r_end got beats=%0d v=%b arready=%b exp beats=%0d v=0 arready=1",
                     tag, beat, axiRValid, axiARReady, len + 1);
        end
    endtask

    task automatic test_reset();
        srst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({axiARReady, axiAWReady, axiWReady, axiRValid, axiRLast, axiBValid,
             axiRResp, axiBResp, axiRId, axiBId, axiRData} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got ar=%b aw=%b w=%b rv=%b bv=%b rd=%h exp all 0",
                     axiARReady, axiAWReady, axiWReady, axiRValid, axiBValid, axiRData);
        end
        srst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({axiARReady, axiAWReady, axiWReady, axiRValid, axiBValid} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_release got %b exp 11000",
                     {axiARReady, axiAWReady, axiWReady, axiRValid, axiBValid});
        end
    endtask

    task automatic test_fill();
        for (int blk = 0; blk < 4; blk++) begin
            for (int b = 0; b < 256; b++) begin
                wbData[b] = rnd128(); wbStrb[b] = '1;
            end
            axi_write(4'(blk), 64'(blk * 4096), 255, 3'd4, 255, "fill");
        end
        axi_read(4'h9, 64'h2000, 255, 3'd4, 0, -1, "fill_rd");
    endtask

    task automatic test_basic();
        wbData[0] = {16{8'h11}}; wbData[1] = {16{8'h22}};
        wbData[2] = {16{8'h33}}; wbData[3] = {16{8'h44}};
        for (int b = 0; b < 4; b++) wbStrb[b] = '1;
        axi_write(4'd3, 64'h40, 3, 3'd4, 3, "basic_wr");
        axi_read(4'd5, 64'h40, 3, 3'd4, 0, -1, "basic_rd");
    endtask

    task automatic test_partial_strobe();
        wbData[0] = {16{8'hFF}}; wbStrb[0] = '1;
        axi_write(4'd1, 64'h123_0000_0A00, 0, 3'd4, 0, "pstrb_wr1");
        wbData[0] = {16{8'hAA}}; wbStrb[0] = 16'h0001;
        axi_write(4'd2, 64'h0A07, 0, 3'd4, 0, "pstrb_wr2");
        axi_read(4'd4, 64'h0A00, 0, 3'd4, 0, -1, "pstrb_rd");
    endtask

    task automatic test_wrap();
        wbData[0] = rnd128(); wbData[1] = rnd128();
        wbStrb[0] = '1; wbStrb[1] = '1;
        axi_write(4'd6, 64'h3FF0, 1, 3'd4, 1, "wrap_wr");
        axi_read(4'd7, 64'h3FF0, 1, 3'd4, 0, -1, "wrap_rd");
        axi_read(4'd8, 64'h0, 0, 3'd4, 0, -1, "wrap_rd0");
    endtask

    task automatic test_backpressure();
        axi_read(4'hA, 64'h100, 7, 3'd4, 1, -1, "bp_rd");
    endtask

    task automatic test_errors();
        axi_read(4'hB, 64'h200, 1, 3'd2, 0, -1, "err_rsize");
        for (int b = 0; b < 4; b++) begin wbData[b] = rnd128(); wbStrb[b] = '1; end
        axi_write(4'hC, 64'h300, 3, 3'd4, 1, "err_early_last");
        axi_read(4'hC, 64'h300, 3, 3'd4, 0, -1, "err_early_rd");
        for (int b = 0; b < 5; b++) begin wbData[b] = rnd128(); wbStrb[b] = '1; end
        axi_write(4'hD, 64'h340, 2, 3'd4, 4, "err_late_last");
        axi_write(4'hE, 64'h380, 1, 3'd5, 1, "err_wsize");
        axi_read(4'hD, 64'h340, 7, 3'd4, 2, -1, "err_late_rd");
    endtask

    task automatic test_reset_midburst();
        axi_read(4'h2, 64'h500, 7, 3'd4, 0, 2, "rst_mid");
        axi_read(4'h3, 64'h500, 7, 3'd4, 0, -1, "rst_mid_rd");
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 8; b++) begin wbData[b] = rnd128(); wbStrb[b] = 16'($urandom); end
        fork
            axi_write(4'h4, 64'h800, 7, 3'd4, 7, "b2b_wr");
            begin
                axi_read(4'h5, 64'h900, 5, 3'd4, 0, -1, "b2b_rd1");
                axi_read(4'h6, 64'h960, 3, 3'd4, 0, -1, "b2b_rd2");
            end
        join
        axi_read(4'h7, 64'h800, 7, 3'd4, 2, -1, "b2b_rd3");
    endtask

    task automatic test_random();
        int len;
        int lastIdx;
        logic [2:0] size;
        logic [63:0] addr;
        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(0, 15);
            addr = {$urandom, $urandom};
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
            lastIdx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len + 2) : len;
            for (int b = 0; b <= lastIdx; b++) begin
                wbData[b] = rnd128(); wbStrb[b] = 16'($urandom);
            end
            axi_write(4'($urandom), addr, len, size, lastIdx, "rnd_wr");
            if ($urandom_range(0, 1) == 0) addr = {$urandom, $urandom};
            size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd4;
            axi_read(4'($urandom), addr, $urandom_range(0, 15), size, 2, -1, "rnd_rd");
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_partial_strobe();
        test_wrap();
        test_backpressure();
        test_errors();
        test_reset_midburst();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/smi_axi_mem_responder.md
# smi_axi_mem_responder

AXI4 slave memory responder: the far end of the AXI read/write ports driven by the SMI-to-AXI memory bus adaptor. It accepts incremental read and write bursts on independent channels, services them from an internal byte-strobed RAM, and returns R beats and B responses. It is the synthesizable memory target for adaptor-level simulation and on-chip scratchpad use.

## Interface
- DataIndexSize, 4: log2 bytes per beat; data width = 8<<DataIndexSize bits, strobe width = 1<<DataIndexSize.
- AxiIdWidth, 4: AXI ID width.
- MemAddrWidth, 10: log2 of RAM depth in beats (default 1024 beats, 16 KiB).
- clk  input  1  single clock; all logic rising-edge.
- srst  input  1  synchronous reset, active-low (srst == 0 resets).
- axiARValid, axiARReady(out), axiARId[AxiIdWidth], axiARAddr[64], axiARLen[8], axiARSize[3], axiARCache[4]: read address; all inputs except axiARReady.
- axiRValid(out), axiRReady(in), axiRId(out)[AxiIdWidth], axiRData(out)[8<<DataIndexSize], axiRResp(out)[2], axiRLast(out): read data.
- axiAWValid, axiAWReady(out), axiAWId[AxiIdWidth], axiAWAddr[64], axiAWLen[8], axiAWSize[3], axiAWCache[4]: write address; all inputs except axiAWReady.
- axiWValid(in), axiWReady(out), axiWData(in)[8<<DataIndexSize], axiWStrb(in)[1<<DataIndexSize], axiWLast(in): write data.
- axiBValid(out), axiBReady(in), axiBId(out)[AxiIdWidth], axiBResp(out)[2]: write response.

## Operation
- Burst type INCR only; axiARCache/axiAWCache ignored. One outstanding burst per channel; read and write channels fully independent.
- Beat index = Addr[DataIndexSize +: MemAddrWidth]; low DataIndexSize address bits ignored; upper bits ignored. Index increments per beat modulo 2^MemAddrWidth (wrap to 0 at top of RAM).
- Read FSM RD_IDLE -> RD_BURST -> RD_IDLE. RD_IDLE: axiARReady=1; on AR handshake capture Id, index, Len, size error flag (axiARSize != DataIndexSize). RD_BURST: present beat with axiRValid=1, axiRId=captured Id, axiRLast=1 when beat count == Len; advance on axiRValid&&axiRReady; last handshake returns to RD_IDLE.
- Read data: RAM word at current index; on size error axiRData=0 and axiRResp=2'b10 (SLVERR) for all Len+1 beats, else 2'b00.
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE. WR_IDLE: axiAWReady=1; capture Id, index, Len, size error. WR_DATA: axiWReady=1; each handshake writes bytes with axiWStrb[i]=1 (unless size error) and increments index and beat count; beats after beat Len discarded. Handshake with axiWLast=1 -> WR_RESP. WR_RESP: axiBValid=1, axiBId=captured Id; axiBResp=SLVERR if size error or WLast beat index != Len, else OKAY; on axiBReady -> WR_IDLE.
- Same-cycle read of a word being written returns old data (read-before-write); write visible to beats presented from the next cycle.
- Reset: both FSMs to IDLE, counters cleared; RAM contents retained. Reset mid-burst abandons the burst with no trailing beats or B response.

## Timing
- Reset values: axiARReady=0, axiAWReady=0, axiWReady=0, axiRValid=0, axiRLast=0, axiBValid=0, axiRResp=0, axiBResp=0, axiRId=0, axiBId=0, axiRData=0. Readys forced 0 while srst=0; asserted first cycle after srst=1.
- AR handshake cycle N -> first R beat valid N+1; one beat per cycle with axiRReady held; R outputs stable while axiRValid&&!axiRReady.
- Final R handshake cycle M -> axiRValid=0 and axiARReady=1 at M+1; minimum one idle cycle between read bursts.
- AW handshake cycle N -> axiWReady=1 at N+1. WLast handshake cycle M -> axiWReady=0, axiBValid=1 at M+1; B handshake cycle K -> axiAWReady=1 at K+1.
- AR/AW not accepted in same cycle as their own channel's final beat.

## Test plan
- Write AWId=3, AWAddr=0x40, AWLen=3, data 0x11..,0x22..,0x33..,0x44.. full strobes -> BId=3, BResp=00; then read ARId=5 same address -> 4 beats matching, RId=5, RLast on 4th, RResp=00.
- Partial strobe: write 0xFFFF.. then write 0xAA.. with WStrb=0x0001 -> read-back byte0=0xAA, bytes1..15=0xFF.
- Wrap: write Len=1 at beat index 1023 (addr 0x3FF0) -> beats land at 1023 and 0; read from 0x3FF0 Len=1 returns both.
- Backpressure: read Len=7 with axiRReady toggling 1010.. -> exactly 8 beats, no duplicate/skipped data, outputs held when stalled.
- Errors: ARSize=2 Len=1 -> 2 beats RData=0 RResp=10; write Len=3 with WLast on beat 1 -> BResp=10, only beats 0-1 written.
- Reset mid-burst: assert srst=0 during beat 2 of 8-beat read -> axiRValid=0 next cycle, axiARReady=1 cycle after release, RAM contents unchanged.
